serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing Diff = A - B - Bin, one bit per clock, LSB first. It is the inverse-direction companion to the team's ripple full-adder datapath. Operands enter through a valid/ready input handshake and the result leaves through a valid/ready output handshake. It sits in arithmetic paths where area matters more than latency.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
Bin  input  1  borrow-in
In_valid  input  1  operands valid
In_ready  output  1  block can accept operands
Diff  output  WIDTH  registered difference
Borrow  output  1  registered final borrow-out
Out_valid  output  1  Diff/Borrow valid
Out_ready  input  1  consumer accepts result

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, Out_valid=0, Diff=0, Borrow=0. Internal shift registers, borrow flop and bit counter are all 0.
- In_ready = (state==IDLE). It is decoded combinationally from state, so it reads 1 from reset onward.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On In_valid & In_ready, capture A, B, Bin into internal shift registers and the borrow flop.
  - Clear the counter and go to RUN.
  - If In_valid=0, stay in IDLE.
- RUN, each cycle:
  - Feed the 1-bit stage with X=a_sh[0], Y=b_sh[0], Bi=borrow.
  - Shift a_sh and b_sh right by 1.
  - Shift the stage's d into the MSB of d_sh, which is shifted right.
  - borrow <= bo; counter++.
  - When counter==WIDTH-1: load Diff <= final d_sh (including this cycle's bit) and Borrow <= bo, set Out_valid=1, go to DONE.
- Latency: handshake accepted at edge k, Out_valid rises at edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum.
- DONE:
  - Diff, Borrow and Out_valid are held stable while Out_ready=0, for unbounded time.
  - In_ready=0; In_valid is ignored and any new operands are not captured.
  - On Out_valid & Out_ready: Out_valid <= 0 and go to IDLE. The same edge cannot accept new operands.
- Diff and Borrow change only on the RUN→DONE transition and otherwise hold their last result, including in IDLE and RUN.
- Arithmetic: unsigned, modulo 2^WIDTH. Borrow=1 iff A < B + Bin.
- Reset mid-RUN or mid-DONE: the block immediately returns to reset values, the in-flight operation is discarded, and no Out_valid pulse is produced.
- Input stability: A/B/Bin are sampled only at the accepting edge. Changes after that edge have no effect.

Decomposition:
- Shared header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter width as ceil(log2(WIDTH)) with a minimum of 1.
- Sub-module full_subtractor (X, Y, Bi → d, bo), purely combinational:
  - d = X^Y^Bi
  - bo = (~X&Y) | (~(X^Y)&Bi)
- The parent holds the FSM, counter, shift registers and output registers.

Test Plan:
- Reset: assert rst mid-RUN (A=9, B=3) → Out_valid=0, In_ready=1, Diff=0, Borrow=0 asynchronously. After release, no stale result ever appears.
- A=9, B=3, Bin=0 with Out_ready=1 → Out_valid high exactly 4 cycles after the accept edge, Diff=6, Borrow=0. In_ready=1 again one cycle later.
- A=3, B=9, Bin=0 → Diff=4'b1010 (10), Borrow=1.
- Wrap: A=0, B=0, Bin=1 → Diff=15, Borrow=1. Also A=15, B=15, Bin=1 → Diff=15, Borrow=1.
- Backpressure: result pending with Out_ready=0 for 5 cycles while In_valid=1, A=1, B=1 is driven → Diff/Borrow/Out_valid constant, In_ready=0, new operands not captured. Raise Out_ready → IDLE next cycle, then the new operands are accepted and give Diff=0.
- Random: 1000 back-to-back operand sets with random Out_ready stalls → every result matches the (A-B-Bin) mod 16 and borrow reference, in order, with no drops or duplicates.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encodings and counter sizing for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(w)) with a floor of 1 so WIDTH=1 still gets a real counter bit
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - 1-bit combinational full subtractor stage
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bi,
  output logic d,
  output logic bo
);

  assign d  = X ^ Y ^ Bi;
  assign bo = (~X & Y) | (~(X ^ Y) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned A - B - Bin, LSB first, valid/ready on both sides
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_sh_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             stage_d, stage_bo;
  logic             last;

  full_subtractor u_stage (
    .X  (a_sh[0]),
    .Y  (b_sh[0]),
    .Bi (borrow),
    .d  (stage_d),
    .bo (stage_bo)
  );

  assign In_ready = (state == IDLE);
  assign last     = (cnt == CW'(WIDTH - 1));
  // Written as a shift/or so WIDTH=1 needs no degenerate slice
  assign d_sh_nxt = (d_sh >> 1) | (WIDTH'(stage_d) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (In_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (Out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      d_sh      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      Diff      <= '0;
      Borrow    <= 1'b0;
      Out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_valid) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          d_sh   <= d_sh_nxt;
          borrow <= stage_bo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            Diff      <= d_sh_nxt;
            Borrow    <= stage_bo;
            Out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (Out_ready) Out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
